// File: rtl/arm_pkg.sv
// Shared register-file definitions for the decode stage.
// Holds the architectural register count, the zero-register index and the index/word types.
package arm_pkg;
    localparam int REG_COUNT = 32;
    localparam logic [4:0] XZR = 5'd31;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [63:0] word_t;
endpackage

// File: rtl/mux32x64_64.sv
// 32:1 read multiplexer for one register-file read port.
// Purely combinational; the caller supplies the zero-register entry as a constant.
module mux32x64_64
    import arm_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_data [REG_COUNT],
    input  logic [4:0]       i_sel,
    output logic [WIDTH-1:0] o_data
);

    assign o_data = i_data[i_sel];

endmodule

// File: rtl/regfile_id_stage.sv
// Decode-stage register file: 31 stored entries plus a constant-zero register,
// two bypassed read ports and the ID/EX operand register with stall/flush.
module regfile_id_stage
    import arm_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       rd_addr_a,
    input  logic [4:0]       rd_addr_b,
    input  logic             id_valid,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] ex_data_a,
    output logic [WIDTH-1:0] ex_data_b,
    output logic [4:0]       ex_addr_a,
    output logic [4:0]       ex_addr_b,
    output logic             ex_valid
);

    localparam reg_idx_t ZR = reg_idx_t'(ZERO_REG);

    logic [REG_COUNT-1:0] w_wr_dec;
    logic [WIDTH-1:0]     w_rf [REG_COUNT];
    logic [WIDTH-1:0]     w_mux_a;
    logic [WIDTH-1:0]     w_mux_b;
    logic [WIDTH-1:0]     w_rd_a;
    logic [WIDTH-1:0]     w_rd_b;
    logic                 w_byp_a;
    logic                 w_byp_b;

    // One-hot write decode; the zero register never receives a write strobe.
    always_comb begin
        w_wr_dec = '0;
        if (wr_en) w_wr_dec[wr_addr] = 1'b1;
        w_wr_dec[ZERO_REG] = 1'b0;
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_entry
        if (g == ZERO_REG) begin : g_zero
            assign w_rf[g] = '0;
        end else begin : g_store
            logic [WIDTH-1:0] r_entry;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)         r_entry <= '0;
                else if (w_wr_dec[g]) r_entry <= wr_data;
            end
            assign w_rf[g] = r_entry;
        end
    end

    mux32x64_64 #(.WIDTH(WIDTH)) u_mux_a (
        .i_data (w_rf),
        .i_sel  (rd_addr_a),
        .o_data (w_mux_a)
    );

    mux32x64_64 #(.WIDTH(WIDTH)) u_mux_b (
        .i_data (w_rf),
        .i_sel  (rd_addr_b),
        .o_data (w_mux_b)
    );

    // Same-cycle writeback is forwarded into decode so the array write is not missed.
    assign w_byp_a = wr_en && (wr_addr == rd_addr_a) && (rd_addr_a != ZR);
    assign w_byp_b = wr_en && (wr_addr == rd_addr_b) && (rd_addr_b != ZR);
    assign w_rd_a  = w_byp_a ? wr_data : w_mux_a;
    assign w_rd_b  = w_byp_b ? wr_data : w_mux_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_data_a <= '0;
            ex_data_b <= '0;
            ex_addr_a <= ZR;
            ex_addr_b <= ZR;
            ex_valid  <= 1'b0;
        end else if (flush) begin
            ex_data_a <= '0;
            ex_data_b <= '0;
            ex_addr_a <= ZR;
            ex_addr_b <= ZR;
            ex_valid  <= 1'b0;
        end else if (!stall) begin
            ex_data_a <= w_rd_a;
            ex_data_b <= w_rd_b;
            ex_addr_a <= rd_addr_a;
            ex_addr_b <= rd_addr_b;
            ex_valid  <= id_valid;
        end
    end

endmodule
